// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID checker.
// Holds the FSM state encoding, the slave word addresses and the data width.
package sysid_check_pkg;

   localparam int   SYSID_DATA_W  = 32;
   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ID   = 3'd1,
      ST_RD_TS   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } sysid_state_t;

   // Counter width able to hold the terminal count itself.
   function automatic int timer_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sysid_check_timer.sv
// Loadable saturating stall counter; o_tc is high once TIMEOUT_CYCLES stalls were counted.
// Only instantiated when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_check_timer
   import sysid_check_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_load,
   input  logic i_count,
   output logic o_tc
);

   localparam int               CNT_W = timer_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TC    = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_count && (r_cnt != TC)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID and timestamp words and flags a mismatched image.
// Optional stall timeout is enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_checker
   import sysid_check_pkg::*;
#(
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'h0000_0000,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
   parameter bit                      AUTO_START         = 1'b1,
   parameter int                      TIMEOUT_CYCLES     = 256
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    avm_address,
   output logic                    avm_read,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   input  logic                    avm_waitrequest,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    fail,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value,
   output logic                    timeout
);

   sysid_state_t            r_state;
   logic                    r_auto_pending;
   logic                    r_read;
   logic                    r_addr;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_pass;
   logic                    r_fail;
   logic                    r_timeout;
   logic [SYSID_DATA_W-1:0] r_id;
   logic [SYSID_DATA_W-1:0] r_ts;

   logic w_in_read;
   logic w_tc;
   logic w_match;

   assign w_in_read = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
   assign w_match   = (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECK_TIMEOUT_EN
   sysid_check_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (!w_in_read || !avm_waitrequest),
      .i_count (w_in_read && avm_waitrequest),
      .o_tc    (w_tc)
   );
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
   assign w_tc         = 1'b0;
`endif

   // NOTE: every output comes straight from a flop, so each transition sets the
   // next-cycle value of read/address/status explicitly rather than decoding r_state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_auto_pending <= AUTO_START;
         r_read         <= 1'b0;
         r_addr         <= SYSID_ADDR_ID;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_pass         <= 1'b0;
         r_fail         <= 1'b0;
         r_timeout      <= 1'b0;
         r_id           <= '0;
         r_ts           <= '0;
      end else begin
         r_auto_pending <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start || r_auto_pending) begin
                  r_state   <= ST_RD_ID;
                  r_read    <= 1'b1;
                  r_addr    <= SYSID_ADDR_ID;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
                  r_fail    <= 1'b0;
                  r_timeout <= 1'b0;
                  r_id      <= '0;
                  r_ts      <= '0;
               end
            end
            ST_RD_ID, ST_RD_TS: begin
               if (w_tc) begin
                  r_state   <= ST_DONE;
                  r_read    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_pass    <= 1'b0;
                  r_fail    <= 1'b1;
                  r_timeout <= 1'b1;
               end else if (!avm_waitrequest) begin
                  if (r_state == ST_RD_ID) begin
                     r_id    <= avm_readdata;
                     r_addr  <= SYSID_ADDR_TS;
                     r_state <= ST_RD_TS;
                  end else begin
                     r_ts    <= avm_readdata;
                     r_read  <= 1'b0;
                     r_state <= ST_COMPARE;
                  end
               end
            end
            ST_COMPARE: begin
               r_pass  <= w_match;
               r_fail  <= !w_match;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_read  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign avm_address = r_addr;
   assign avm_read    = r_read;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign id_value    = r_id;
   assign ts_value    = r_ts;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: table vectors, random vectors against a
// reference model, and hand-written sequences for start/reset corner cases.
module tb_sysid_checker;
   import sysid_check_pkg::*;

   localparam logic [31:0] EXP_ID  = 32'h0000_0000;
   localparam logic [31:0] EXP_TS  = 32'h5121_3A5E;
   localparam int          TO_CYC  = 8;
   localparam int          MAX_LAT = 40;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy, done, pass, fail, timeout;
   logic [31:0] id_value, ts_value;
   logic [31:0] slave_id, slave_ts;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] rd_id;
      logic [31:0] rd_ts;
      int          stall_id;
      int          stall_ts;
      bit          exp_pass;
      bit          exp_fail;
      bit          exp_to;
      logic [31:0] exp_id;
      logic [31:0] exp_ts;
      int          exp_lat;
   } vec_t;

   sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .AUTO_START         (1'b1),
      .TIMEOUT_CYCLES     (TO_CYC)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .fail            (fail),
      .id_value        (id_value),
      .ts_value        (ts_value),
      .timeout         (timeout)
   );

   // Simple system-ID slave: the word at each address is whatever the test loaded.
   assign avm_readdata = avm_address ? slave_ts : slave_id;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected outcome of one check, derived from the matching rules and handshake latency.
   function automatic vec_t ref_model(input logic [31:0] rid, input logic [31:0] rts,
                                      input int sid, input int sts);
      vec_t v;
      v.rd_id    = rid;
      v.rd_ts    = rts;
      v.stall_id = sid;
      v.stall_ts = sts;
      v.exp_pass = (rid == EXP_ID) && (rts == EXP_TS);
      v.exp_fail = !v.exp_pass;
      v.exp_to   = 1'b0;
      v.exp_id   = rid;
      v.exp_ts   = rts;
      v.exp_lat  = 3 + sid + sts;
      return v;
   endfunction

   // Kick one check (start pulse or reset release), act as a stalling slave, compare result.
   task automatic run_check(input string name, input vec_t v, input bit via_reset);
      int   k;
      int   id_left;
      int   ts_left;
      bit   stable;
      bit   busy_ok;
      bit   prev_stall;
      logic prev_addr;
      bit   seen;
      slave_id   = v.rd_id;
      slave_ts   = v.rd_ts;
      id_left    = v.stall_id;
      ts_left    = v.stall_ts;
      stable     = 1'b1;
      busy_ok    = 1'b1;
      prev_stall = 1'b0;
      prev_addr  = 1'b0;
      seen       = 1'b0;
      k          = 0;
      @(negedge clock);
      if (via_reset) reset_n = 1'b1;
      else           start   = 1'b1;
      avm_waitrequest = 1'b0;
      @(posedge clock);
      while (k <= MAX_LAT) begin
         @(negedge clock);
         start = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (prev_stall && !(avm_read === 1'b1 && avm_address === prev_addr)) stable = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
         prev_stall = 1'b0;
         if (avm_read === 1'b1 && avm_address === SYSID_ADDR_ID && id_left > 0) begin
            avm_waitrequest = 1'b1;
            id_left--;
            prev_stall = 1'b1;
            prev_addr  = SYSID_ADDR_ID;
         end else if (avm_read === 1'b1 && avm_address === SYSID_ADDR_TS && ts_left > 0) begin
            avm_waitrequest = 1'b1;
            ts_left--;
            prev_stall = 1'b1;
            prev_addr  = SYSID_ADDR_TS;
         end else begin
            avm_waitrequest = 1'b0;
         end
         @(posedge clock);
         k++;
      end
      avm_waitrequest = 1'b0;
      check({name, " done_seen"}, 32'(seen), 32'd1);
      check({name, " latency"},   k,            v.exp_lat);
      check({name, " pass"},      32'(pass),    32'(v.exp_pass));
      check({name, " fail"},      32'(fail),    32'(v.exp_fail));
      check({name, " timeout"},   32'(timeout), 32'(v.exp_to));
      check({name, " id_value"},  id_value,     v.exp_id);
      check({name, " ts_value"},  ts_value,     v.exp_ts);
      check({name, " idle_bus"},  {30'd0, busy, avm_read}, 32'd0);
      check({name, " stall_stable"}, 32'(stable),  32'd1);
      check({name, " busy_during"},  32'(busy_ok), 32'd1);
   endtask

   vec_t tbl[5];

   initial begin
      vec_t v;
      tbl[0] = '{32'h0000_0000, 32'h5121_3A5E, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h5121_3A5E, 3};
      tbl[1] = '{32'h0000_0000, 32'h5121_3A5F, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h5121_3A5F, 3};
      tbl[2] = '{32'h0000_0000, 32'h5121_3A5E, 5, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h5121_3A5E, 8};
      tbl[3] = '{32'h0000_0001, 32'h5121_3A5E, 0, 2, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h5121_3A5E, 5};
      tbl[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 1, 3, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 7};

      reset_n         = 1'b1;
      start           = 1'b0;
      avm_waitrequest = 1'b0;
      slave_id        = EXP_ID;
      slave_ts        = EXP_TS;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset outputs", {26'd0, avm_read, avm_address, busy, done, pass, fail}, 32'd0);
      check("reset id/ts", id_value | ts_value, 32'd0);
      check("reset timeout", 32'(timeout), 32'd0);

      // Auto start: first edge after release is edge N.
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("auto N read/addr/busy", {29'd0, avm_read, avm_address, busy}, 32'b101);
      @(posedge clock); #1;
      check("auto N+1 read/addr", {30'd0, avm_read, avm_address}, 32'b11);
      check("auto N+1 id_value", id_value, EXP_ID);
      @(posedge clock); #1;
      check("auto N+2 read/busy/done", {29'd0, avm_read, busy, done}, 32'b010);
      check("auto N+2 ts_value", ts_value, EXP_TS);
      @(posedge clock); #1;
      check("auto N+3 done/pass/fail/busy", {28'd0, done, pass, fail, busy}, 32'b1100);

      foreach (tbl[i]) run_check($sformatf("tbl%0d", i), tbl[i], 1'b0);

      for (int i = 0; i < 16; i++) begin
         logic [31:0] rid;
         logic [31:0] rts;
         rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
         rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
         v = ref_model(rid, rts, $urandom_range(0, 4), $urandom_range(0, 4));
         run_check($sformatf("rnd%0d", i), v, 1'b0);
      end

      // Start during RD_TS is ignored; exactly one check completes.
      slave_id = EXP_ID;
      slave_ts = EXP_TS;
      @(negedge clock); start = 1'b1;
      @(posedge clock);
      @(negedge clock); start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("ignore: in RD_TS", {30'd0, avm_read, avm_address}, 32'b11);
      start = 1'b1;
      avm_waitrequest = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      avm_waitrequest = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("ignore: compare busy/done", {30'd0, busy, done}, 32'b10);
      @(negedge clock);
      check("ignore: done/pass", {30'd0, done, pass}, 32'b11);
      repeat (3) @(negedge clock);
      check("ignore: no rerun", {29'd0, done, busy, avm_read}, 32'b100);

      // Back-to-back start in DONE clears the result on the same edge.
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("b2b: status cleared", {27'd0, done, pass, fail, busy, avm_read}, 32'b00011);
      check("b2b: address", 32'(avm_address), 32'(SYSID_ADDR_ID));
      repeat (3) @(posedge clock);
      #1;
      check("b2b: completes", {29'd0, done, pass, fail}, 32'b110);

      // Reset during RD_TS drops the bus and all status immediately.
      @(negedge clock); start = 1'b1;
      @(posedge clock);
      @(negedge clock); start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rst: in RD_TS", {30'd0, avm_read, avm_address}, 32'b11);
      avm_waitrequest = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst: async clear", {26'd0, avm_read, avm_address, busy, done, pass, fail}, 32'd0);
      check("rst: id cleared", id_value, 32'd0);
      avm_waitrequest = 1'b0;
      v = ref_model(EXP_ID, EXP_TS, 0, 0);
      run_check("rst rerun", v, 1'b1);

`ifdef SYSID_CHECK_TIMEOUT_EN
      v          = ref_model(32'h1234_5678, EXP_TS, 100, 0);
      v.exp_pass = 1'b0;
      v.exp_fail = 1'b1;
      v.exp_to   = 1'b1;
      v.exp_id   = 32'd0;
      v.exp_ts   = 32'd0;
      v.exp_lat  = TO_CYC + 1;
      run_check("timeout", v, 1'b0);
      v = ref_model(EXP_ID, EXP_TS, 0, 0);
      run_check("after timeout", v, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
